// File: rtl/bcd_stopwatch.sv
// BCD stopwatch / countdown timer for the OSD overlay, with lap capture and status flags.
// Digit 0 is the lowest hundredths digit (PL); digits 6.. are hours, least significant first.
module bcd_stopwatch #(
    parameter int HOUR_DIGITS = 1
) (
    input  logic                          gClk,
    input  logic                          nRST,
    input  logic                          run,
    input  logic                          clear,
    input  logic                          dirDown,
    input  logic                          load,
    input  logic [4*(6+HOUR_DIGITS)-1:0]  loadValue,
    input  logic                          gPercentEna,
    input  logic                          gSecondEna,
    input  logic                          lapCapture,
    input  logic                          lapRelease,
    output logic [4*(6+HOUR_DIGITS)-1:0]  liveBcd,
    output logic [4*(6+HOUR_DIGITS)-1:0]  dispBcd,
    output logic                          lapValid,
    output logic                          saturated,
    output logic                          expired,
    output logic                          running
);

    localparam int D = 6 + HOUR_DIGITS;

    typedef logic [D-1:0][3:0] bcd_t;

    bcd_t       r_count;
    bcd_t       r_lap;
    logic       r_lap_valid;
    logic       r_sat;
    logic       r_exp;

    bcd_t       w_load;
    bcd_t       w_max;
    bcd_t       w_sec_up;
    bcd_t       w_sec_dn;
    logic [D:2] w_carry;
    logic [D:2] w_borrow;
    logic [1:0][3:0] w_hund_up;
    logic [1:0][3:0] w_hund_dn;
    bcd_t       w_next;
    logic       w_next_sat;
    logic       w_next_exp;
    logic       w_tick;

    assign w_carry[2]  = 1'b1;
    assign w_borrow[2] = 1'b1;

    // Per-digit limits: tens of seconds and tens of minutes stop at 5, everything else at 9.
    for (genvar i = 0; i < D; i++) begin : g_digit
        localparam logic [3:0] LIM = (i == 3 || i == 5) ? 4'd5 : 4'd9;

        assign w_load[i] = (loadValue[4*i +: 4] > LIM) ? LIM : loadValue[4*i +: 4];
        assign w_max[i]  = LIM;

        if (i < 2) begin : g_hund
            assign w_sec_up[i] = 4'd0;
            assign w_sec_dn[i] = 4'd9;
        end else begin : g_chain
            assign w_sec_up[i]   = !w_carry[i]  ? r_count[i] :
                                   (r_count[i] == LIM) ? 4'd0 : r_count[i] + 4'd1;
            assign w_carry[i+1]  = w_carry[i] & (r_count[i] == LIM);
            assign w_sec_dn[i]   = !w_borrow[i] ? r_count[i] :
                                   (r_count[i] == 4'd0) ? LIM : r_count[i] - 4'd1;
            assign w_borrow[i+1] = w_borrow[i] & (r_count[i] == 4'd0);
        end
    end

    // Hundredths saturate in both directions and never ripple into seconds.
    always_comb begin
        // NOTE: every comb output gets a default first so no path can infer a latch.
        w_hund_up = r_count[1:0];
        w_hund_dn = r_count[1:0];
        if (r_count[1:0] != 8'h99) begin
            if (r_count[0] == 4'd9) w_hund_up = {r_count[1] + 4'd1, 4'd0};
            else                    w_hund_up = {r_count[1], r_count[0] + 4'd1};
        end
        if (r_count[1:0] != 8'h00) begin
            if (r_count[0] == 4'd0) w_hund_dn = {r_count[1] - 4'd1, 4'd9};
            else                    w_hund_dn = {r_count[1], r_count[0] - 4'd1};
        end
    end

    assign w_tick = run & ~r_sat & (gSecondEna | gPercentEna);

    always_comb begin
        w_next     = r_count;
        w_next_sat = r_sat;
        if (clear) begin
            w_next     = '0;
            w_next_sat = 1'b0;
        end else if (load) begin
            w_next     = w_load;
            w_next_sat = 1'b0;
        end else if (run && !r_sat) begin
            if (gSecondEna) begin
                if (!dirDown) begin
                    if (w_carry[D]) begin
                        w_next     = w_max;
                        w_next_sat = 1'b1;
                    end else begin
                        w_next = w_sec_up;
                    end
                end else begin
                    // w_borrow[D] means seconds through hours are already zero.
                    w_next = w_borrow[D] ? '0 : w_sec_dn;
                end
            end else if (gPercentEna) begin
                w_next[1:0] = dirDown ? w_hund_dn : w_hund_up;
            end
        end
        w_next_exp = w_tick & dirDown & ~clear & ~load & (r_count != '0) & (w_next == '0);
    end

    always_ff @(posedge gClk) begin
        // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
        if (!nRST) begin
            r_count     <= '0;
            r_lap       <= '0;
            r_lap_valid <= 1'b0;
            r_sat       <= 1'b0;
            r_exp       <= 1'b0;
        end else begin
            r_count <= w_next;
            r_sat   <= w_next_sat;
            r_exp   <= w_next_exp;
            if (clear) begin
                r_lap_valid <= 1'b0;
            end else if (lapCapture) begin
                r_lap       <= w_next;
                r_lap_valid <= 1'b1;
            end else if (lapRelease) begin
                r_lap_valid <= 1'b0;
            end
        end
    end

    assign liveBcd   = r_count;
    assign dispBcd   = r_lap_valid ? r_lap : r_count;
    assign lapValid  = r_lap_valid;
    assign saturated = r_sat;
    assign expired   = r_exp;
    assign running   = run & ~r_sat & ~(dirDown & (r_count == '0));

endmodule

// File: tb/tb_bcd_stopwatch.sv
// Self-checking bench for bcd_stopwatch: one-hour-digit and three-hour-digit instances
// driven in parallel and compared against a seconds/hundredths arithmetic model.
module tb_bcd_stopwatch;

    logic gClk = 1'b0;
    always #5 gClk = ~gClk;

    logic        nRST, run, clear, dirDown, load;
    logic        gPercentEna, gSecondEna, lapCapture, lapRelease;
    logic [35:0] ld;

    logic [27:0] live1, disp1;
    logic        lv1, sat1, exp1, run1;
    logic [35:0] live3, disp3;
    logic        lv3, sat3, exp3, run3;

    int checks   = 0;
    int failures = 0;

    bcd_stopwatch #(.HOUR_DIGITS(1)) dut1 (
        .gClk(gClk), .nRST(nRST), .run(run), .clear(clear), .dirDown(dirDown),
        .load(load), .loadValue(ld[27:0]), .gPercentEna(gPercentEna),
        .gSecondEna(gSecondEna), .lapCapture(lapCapture), .lapRelease(lapRelease),
        .liveBcd(live1), .dispBcd(disp1), .lapValid(lv1), .saturated(sat1),
        .expired(exp1), .running(run1)
    );

    bcd_stopwatch #(.HOUR_DIGITS(3)) dut3 (
        .gClk(gClk), .nRST(nRST), .run(run), .clear(clear), .dirDown(dirDown),
        .load(load), .loadValue(ld), .gPercentEna(gPercentEna),
        .gSecondEna(gSecondEna), .lapCapture(lapCapture), .lapRelease(lapRelease),
        .liveBcd(live3), .dispBcd(disp3), .lapValid(lv3), .saturated(sat3),
        .expired(exp3), .running(run3)
    );

    // Reference model: elapsed whole seconds plus a separate hundredths field.
    int          m_secs [2];
    int          m_h    [2];
    bit          m_sat  [2];
    bit          m_exp  [2];
    bit          m_lv   [2];
    logic [35:0] m_lap  [2];
    int          hd_of  [2] = '{1, 3};

    function automatic int max_secs(input int hd);
        int p = 1;
        for (int i = 0; i < hd; i++) p = p * 10;
        return (p - 1) * 3600 + 3599;
    endfunction

    function automatic logic [35:0] to_bcd(input int secs, input int h);
        logic [35:0] b;
        int hrs = secs / 3600;
        int m   = (secs / 60) % 60;
        int s   = secs % 60;
        b[3:0]   = 4'(h % 10);
        b[7:4]   = 4'(h / 10);
        b[11:8]  = 4'(s % 10);
        b[15:12] = 4'(s / 10);
        b[19:16] = 4'(m % 10);
        b[23:20] = 4'(m / 10);
        b[27:24] = 4'(hrs % 10);
        b[31:28] = 4'((hrs / 10) % 10);
        b[35:32] = 4'((hrs / 100) % 10);
        return b;
    endfunction

    task automatic model_edge();
        int hd, mx, hrs, lim;
        int dg [9];
        bit was_zero;
        for (int k = 0; k < 2; k++) begin
            hd = hd_of[k];
            mx = max_secs(hd);
            if (!nRST) begin
                m_secs[k] = 0; m_h[k] = 0; m_sat[k] = 0; m_exp[k] = 0;
                m_lv[k] = 0; m_lap[k] = '0;
            end else begin
                was_zero = (m_secs[k] == 0) && (m_h[k] == 0);
                m_exp[k] = 0;
                if (clear) begin
                    m_secs[k] = 0; m_h[k] = 0; m_sat[k] = 0;
                end else if (load) begin
                    for (int i = 0; i < 6 + hd; i++) begin
                        lim   = (i == 3 || i == 5) ? 5 : 9;
                        dg[i] = int'(ld[4*i +: 4]);
                        if (dg[i] > lim) dg[i] = lim;
                    end
                    hrs = 0;
                    for (int i = hd - 1; i >= 0; i--) hrs = hrs * 10 + dg[6+i];
                    m_secs[k] = hrs * 3600 + (dg[5] * 10 + dg[4]) * 60 + dg[3] * 10 + dg[2];
                    m_h[k]    = dg[1] * 10 + dg[0];
                    m_sat[k]  = 0;
                end else if (run && !m_sat[k] && (gSecondEna || gPercentEna)) begin
                    if (gSecondEna) begin
                        if (!dirDown) begin
                            if (m_secs[k] == mx) begin
                                m_h[k] = 99; m_sat[k] = 1;
                            end else begin
                                m_secs[k]++; m_h[k] = 0;
                            end
                        end else if (m_secs[k] == 0) begin
                            m_h[k] = 0;
                        end else begin
                            m_secs[k]--; m_h[k] = 99;
                        end
                    end else if (!dirDown) begin
                        if (m_h[k] < 99) m_h[k]++;
                    end else begin
                        if (m_h[k] > 0) m_h[k]--;
                    end
                    if (dirDown && !was_zero && m_secs[k] == 0 && m_h[k] == 0) m_exp[k] = 1;
                end
                if (clear) begin
                    m_lv[k] = 0;
                end else if (lapCapture) begin
                    m_lap[k] = to_bcd(m_secs[k], m_h[k]);
                    m_lv[k]  = 1;
                end else if (lapRelease) begin
                    m_lv[k] = 0;
                end
            end
        end
    endtask

    function automatic logic [75:0] exp_state(input int k);
        logic [35:0] live_v, disp_v;
        bit zero;
        live_v = to_bcd(m_secs[k], m_h[k]);
        disp_v = m_lv[k] ? m_lap[k] : live_v;
        zero   = (m_secs[k] == 0) && (m_h[k] == 0);
        return {disp_v, live_v, m_lv[k], m_sat[k], m_exp[k],
                run & ~m_sat[k] & ~(dirDown & zero)};
    endfunction

    function automatic logic [75:0] act_state(input int k);
        if (k == 0) return {8'h0, disp1, 8'h0, live1, lv1, sat1, exp1, run1};
        return {disp3, live3, lv3, sat3, exp3, run3};
    endfunction

    // One clock edge: model follows the same sampled inputs, then pulses drop.
    task automatic cyc();
        @(posedge gClk);
        model_edge();
        #1;
        clear = 0; load = 0; gPercentEna = 0; gSecondEna = 0;
        lapCapture = 0; lapRelease = 0;
    endtask

    task automatic test_reset();
        nRST = 0; run = 1; dirDown = 0; clear = 0; load = 1; ld = 36'h012345678;
        gPercentEna = 1; gSecondEna = 1; lapCapture = 1; lapRelease = 0;
        cyc();
        cyc();
        checks++;
        if ({live1, disp1, lv1, sat1, exp1} !== 59'h0 || {live3, disp3, lv3, sat3, exp3} !== 75'h0) begin
            failures++;
            $display("FAIL reset_state: live1=%h sat1=%b live3=%h sat3=%b required all zero",
                     live1, sat1, live3, sat3);
        end
        nRST = 1;
        for (int k = 0; k < 2; k++) begin
            checks++;
            if (act_state(k) !== exp_state(k)) begin
                failures++;
                $display("FAIL reset_model dut%0d: got %h required %h", k, act_state(k), exp_state(k));
            end
        end
    endtask

    task automatic test_up_count();
        run = 1; dirDown = 0; clear = 1;
        cyc();
        repeat (10) begin gPercentEna = 1; cyc(); end
        gSecondEna = 1; cyc();
        repeat (150) begin gPercentEna = 1; cyc(); end
        checks++;
        if (live1 !== 28'h0000199) begin
            failures++;
            $display("FAIL up_hund_saturate: got %h required 0000199", live1);
        end
        gSecondEna = 1; cyc();
        checks++;
        if (live1 !== 28'h0000200) begin
            failures++;
            $display("FAIL up_second_clears_hund: got %h required 0000200", live1);
        end
        for (int k = 0; k < 2; k++) begin
            checks++;
            if (act_state(k) !== exp_state(k)) begin
                failures++;
                $display("FAIL up_model dut%0d: got %h required %h", k, act_state(k), exp_state(k));
            end
        end
    endtask

    task automatic test_saturate();
        run = 1; dirDown = 0; load = 1; ld = 36'h009595800;
        cyc();
        gSecondEna = 1; cyc();
        checks++;
        if (live1 !== 28'h9595900 || sat1 !== 1'b0) begin
            failures++;
            $display("FAIL sat_first_tick: got %h sat=%b required 9595900 sat=0", live1, sat1);
        end
        gSecondEna = 1; cyc();
        checks++;
        if (live1 !== 28'h9595999 || sat1 !== 1'b1 || run1 !== 1'b0) begin
            failures++;
            $display("FAIL sat_overflow: got %h sat=%b running=%b required 9595999 sat=1 running=0",
                     live1, sat1, run1);
        end
        repeat (3) begin gSecondEna = 1; cyc(); gPercentEna = 1; cyc(); end
        checks++;
        if (live1 !== 28'h9595999 || sat1 !== 1'b1) begin
            failures++;
            $display("FAIL sat_hold: got %h sat=%b required 9595999 sat=1", live1, sat1);
        end
        for (int k = 0; k < 2; k++) begin
            checks++;
            if (act_state(k) !== exp_state(k)) begin
                failures++;
                $display("FAIL sat_model dut%0d: got %h required %h", k, act_state(k), exp_state(k));
            end
        end
        clear = 1; cyc();
        checks++;
        if (live1 !== 28'h0 || sat1 !== 1'b0) begin
            failures++;
            $display("FAIL sat_clear: got %h sat=%b required 0 sat=0", live1, sat1);
        end
    endtask

    task automatic test_down();
        run = 1; dirDown = 1; load = 1; ld = 36'h000010000;
        cyc();
        gSecondEna = 1; cyc();
        checks++;
        if (live1 !== 28'h0005999) begin
            failures++;
            $display("FAIL down_borrow: got %h required 0005999", live1);
        end
        load = 1; ld = 36'h000000100; cyc();
        gSecondEna = 1; cyc();
        checks++;
        if (live1 !== 28'h0000099 || exp1 !== 1'b0) begin
            failures++;
            $display("FAIL down_to_99: got %h expired=%b required 0000099 expired=0", live1, exp1);
        end
        gSecondEna = 1; cyc();
        checks++;
        if (live1 !== 28'h0 || exp1 !== 1'b1 || exp3 !== 1'b1 || run1 !== 1'b0) begin
            failures++;
            $display("FAIL down_expire: got %h expired=%b/%b running=%b required 0 expired=1/1 running=0",
                     live1, exp1, exp3, run1);
        end
        cyc();
        checks++;
        if (exp1 !== 1'b0) begin
            failures++;
            $display("FAIL expire_one_cycle: got expired=%b required 0", exp1);
        end
        gSecondEna = 1; cyc();
        gPercentEna = 1; cyc();
        checks++;
        if (exp1 !== 1'b0 || live1 !== 28'h0) begin
            failures++;
            $display("FAIL expire_at_zero: got %h expired=%b required 0 expired=0", live1, exp1);
        end
    endtask

    task automatic test_clamp();
        load = 1; ld = 36'h00F7A9BCD; cyc();
        checks++;
        if (live1 !== 28'h9595999) begin
            failures++;
            $display("FAIL load_clamp: got %h required 9595999", live1);
        end
        checks++;
        if (live3 !== 36'h009595999) begin
            failures++;
            $display("FAIL load_clamp_h3: got %h required 009595999", live3);
        end
    endtask

    task automatic test_lap();
        run = 1; dirDown = 0; clear = 1; cyc();
        repeat (5) begin gSecondEna = 1; cyc(); end
        lapCapture = 1; cyc();
        repeat (3) begin gSecondEna = 1; cyc(); end
        checks++;
        if (disp1 !== 28'h0000500 || live1 !== 28'h0000800 || lv1 !== 1'b1) begin
            failures++;
            $display("FAIL lap_hold: disp=%h live=%h lapValid=%b required 0000500 0000800 1",
                     disp1, live1, lv1);
        end
        lapRelease = 1; cyc();
        checks++;
        if (disp1 !== 28'h0000800 || lv1 !== 1'b0) begin
            failures++;
            $display("FAIL lap_release: disp=%h lapValid=%b required 0000800 0", disp1, lv1);
        end
        lapCapture = 1; lapRelease = 1; gSecondEna = 1; cyc();
        checks++;
        if (lv1 !== 1'b1 || disp1 !== 28'h0000900) begin
            failures++;
            $display("FAIL lap_capture_wins: lapValid=%b disp=%h required 1 0000900", lv1, disp1);
        end
    endtask

    task automatic test_priority();
        run = 1; dirDown = 0;
        clear = 1; load = 1; ld = 36'h001234567; gSecondEna = 1; cyc();
        checks++;
        if (live1 !== 28'h0 || lv1 !== 1'b0) begin
            failures++;
            $display("FAIL prio_clear: got %h lapValid=%b required 0 0", live1, lv1);
        end
        load = 1; ld = 36'h000001050; cyc();
        gSecondEna = 1; gPercentEna = 1; cyc();
        checks++;
        if (live1 !== 28'h0001100) begin
            failures++;
            $display("FAIL prio_second_over_pct: got %h required 0001100", live1);
        end
        lapCapture = 1; cyc();
        nRST = 0; gSecondEna = 1; cyc();
        checks++;
        if ({live1, disp1, lv1, sat1, exp1} !== 59'h0 || live3 !== 36'h0) begin
            failures++;
            $display("FAIL reset_mid_run: live=%h disp=%h lapValid=%b required all zero", live1, disp1, lv1);
        end
        nRST = 1;
        load = 1; ld = 36'h099595900; cyc();
        gSecondEna = 1; cyc();
        checks++;
        if (live3 !== 36'h100000000 || sat3 !== 1'b0) begin
            failures++;
            $display("FAIL h3_rollover: got %h sat=%b required 100000000 sat=0", live3, sat3);
        end
    endtask

    task automatic test_random();
        logic [63:0] r;
        int sel;
        for (int n = 0; n < 4000; n++) begin
            nRST        = ($urandom_range(0, 299) != 0);
            run         = ($urandom_range(0, 7) != 0);
            if ($urandom_range(0, 49) == 0) dirDown = ~dirDown;
            clear       = ($urandom_range(0, 199) == 0);
            load        = ($urandom_range(0, 59) == 0);
            gSecondEna  = ($urandom_range(0, 5) == 0);
            gPercentEna = ($urandom_range(0, 1) == 0);
            lapCapture  = ($urandom_range(0, 39) == 0);
            lapRelease  = ($urandom_range(0, 39) == 0);
            if (load) begin
                sel = $urandom_range(0, 2);
                r   = {$urandom(), $urandom()};
                if (sel == 0)      ld = r[35:0];
                else if (sel == 1) ld = {26'h0, 2'(r[9:8]), r[7:0]};
                else               ld = {8'h99, 20'h95959, r[7:0]};
            end
            cyc();
            for (int k = 0; k < 2; k++) begin
                checks++;
                if (act_state(k) !== exp_state(k)) begin
                    failures++;
                    $display("FAIL random dut%0d step %0d: got %h required %h",
                             k, n, act_state(k), exp_state(k));
                end
            end
        end
    endtask

    initial begin
        for (int k = 0; k < 2; k++) begin
            m_secs[k] = 0; m_h[k] = 0; m_sat[k] = 0; m_exp[k] = 0; m_lv[k] = 0; m_lap[k] = '0;
        end
        test_reset();
        test_up_count();
        test_saturate();
        test_down();
        test_clamp();
        test_lap();
        test_priority();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
